// File: rtl/rco_freq_meter.sv
// Two-channel ring-VCO frequency meter.
// Holds both oscillators in reset, releases them, and counts synchronized
// rising edges of each oscillator over a window of gate_len clk cycles.
// The latched counts are read out one byte at a time through dout.
module rco_freq_meter #(
  parameter int COUNT_W    = 16,
  parameter int GATE_W     = 16,
  parameter int RST_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [1:0]        osc_in,
  output logic [1:0]        osc_rst,
  output logic              busy,
  output logic              done,
  output logic [1:0]        ovf,
  input  logic [1:0]        sel,
  output logic [7:0]        dout
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]    RC_LOAD = RC_W'(RST_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // S_ARM is the acceptance cycle: gate_len is latched and done cleared,
  // the oscillator reset window begins on the following edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_ORST = 2'd2,
    S_GATE = 2'd3
  } state_t;

  state_t state_q;

  logic [GATE_W-1:0]       gate_q;
  logic [GATE_W-1:0]       gcnt_q;
  logic [RC_W-1:0]         rcnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic [1:0]              osc_rst_q;
  logic [1:0]              ovf_q;
  logic [1:0][COUNT_W-1:0] res_q;

  logic [1:0]              sync1_q, sync1_d;
  logic [1:0]              sync2_q, sync2_d;
  logic [1:0]              hist_q,  hist_d;
  logic [1:0]              edge_pls;

  logic [1:0][COUNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]              sat_q, sat_d;

  logic [15:0]             res_ext;
  logic [7:0]              dout_q, dout_d;

  // Two-flop synchronizer plus one history flop per oscillator input.
  always_comb begin
    sync1_d = osc_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  assign edge_pls = sync2_q & ~hist_q;

  // Edge counters: cleared while arming, saturating increment during the gate.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (state_q == S_ARM) begin
      cnt_d = '0;
      sat_d = '0;
    end else if (state_q == S_GATE) begin
      for (int c = 0; c < 2; c++) begin
        if (edge_pls[c]) begin
          if (cnt_q[c] == CNT_MAX) begin
            sat_d[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + COUNT_W'(1);
          end
        end
      end
    end
  end

  // Byte readout: bits at and above COUNT_W are zero by the extension.
  always_comb begin
    res_ext = 16'(res_q[sel[1]]);
    dout_d  = sel[0] ? res_ext[15:8] : res_ext[7:0];
  end

  // Synchronizer, counter and readout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= '0;
      dout_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      dout_q  <= dout_d;
    end
  end

  // Measurement sequencer with registered control outputs. Results are
  // taken from cnt_d so an edge seen in the final gate cycle is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gate_q    <= '0;
      gcnt_q    <= '0;
      rcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      osc_rst_q <= 2'b00;
      ovf_q     <= 2'b00;
      res_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            gate_q  <= gate_len;
            done_q  <= 1'b0;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          rcnt_q    <= RC_LOAD;
          busy_q    <= 1'b1;
          osc_rst_q <= 2'b11;
          state_q   <= S_ORST;
        end
        S_ORST: begin
          if (rcnt_q == RC_W'(1)) begin
            osc_rst_q <= 2'b00;
            if (gate_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              res_q   <= cnt_d;
              ovf_q   <= sat_d;
              state_q <= S_IDLE;
            end else begin
              gcnt_q  <= gate_q;
              state_q <= S_GATE;
            end
          end else begin
            rcnt_q <= rcnt_q - RC_W'(1);
          end
        end
        S_GATE: begin
          if (gcnt_q == GATE_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= cnt_d;
            ovf_q   <= sat_d;
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q - GATE_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign osc_rst = osc_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_rco_freq_meter.sv
// Bench for rco_freq_meter: a 16-bit and an 8-bit counter instance share
// the same stimulus and are compared every cycle against a timeline model.
module tb_rco_freq_meter;

  localparam int R = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] gate_len;
  logic [1:0]  osc_in;
  logic [1:0]  sel;
  logic [1:0]  osc_rst_a, osc_rst_b, ovf_a, ovf_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [7:0]  dout_a, dout_b;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;
  bit sel_rand = 0;
  int mode[2];
  int per[2];
  int ph[2];

  // Reference model state: m_t counts edges since the accepting edge.
  bit         m_act;
  int         m_t, m_g;
  int         mc[2];
  int         mres[2];
  logic [1:0] m_prev;
  logic       m_busy, m_done;
  logic [1:0] m_orst;
  logic [7:0] m_dout_a, m_dout_b;

  rco_freq_meter #(.COUNT_W(16), .GATE_W(16), .RST_CYCLES(R)) dut_a (
    .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .osc_in(osc_in),
    .osc_rst(osc_rst_a), .busy(busy_a), .done(done_a), .ovf(ovf_a),
    .sel(sel), .dout(dout_a)
  );

  rco_freq_meter #(.COUNT_W(8), .GATE_W(16), .RST_CYCLES(R)) dut_b (
    .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .osc_in(osc_in),
    .osc_rst(osc_rst_b), .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .sel(sel), .dout(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [7:0] byte_of(input int raw, input int w, input logic hi);
    int sat;
    sat = (raw > (1 << w) - 1) ? (1 << w) - 1 : raw;
    return hi ? 8'((sat >> 8) & 255) : 8'(sat & 255);
  endfunction

  // Oscillator and readout-select stimulus, changed away from the active edge.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      case (mode[c])
        0: osc_in[c] = 1'b0;
        1: begin
          ph[c]++;
          if (ph[c] >= per[c] / 2) begin
            ph[c] = 0;
            osc_in[c] = ~osc_in[c];
          end
        end
        default: osc_in[c] = 1'($urandom_range(0, 1));
      endcase
    end
    if (sel_rand) sel = 2'($urandom_range(0, 3));
  end

  // Timeline model: a rising edge seen at sample k (k edges after acceptance)
  // is counted when R <= k <= R+G-1; done appears at edge R+1+G.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_t = 0; m_g = 0;
      mc[0] = 0; mc[1] = 0; mres[0] = 0; mres[1] = 0;
      m_busy = 0; m_done = 0; m_orst = 2'b00;
      m_dout_a = 8'h00; m_dout_b = 8'h00;
      m_prev = osc_in;
    end else begin
      m_dout_a = byte_of(mres[sel[1]], 16, sel[0]);
      m_dout_b = byte_of(mres[sel[1]], 8, sel[0]);
      if (m_act) begin
        m_t++;
        if (m_t >= R && m_t <= R + m_g - 1) begin
          for (int c = 0; c < 2; c++)
            if (osc_in[c] && !m_prev[c]) mc[c]++;
        end
        if (m_t == R + 1 + m_g) begin
          mres[0] = mc[0]; mres[1] = mc[1];
          m_done = 1; m_act = 0;
        end
      end else if (start) begin
        m_act = 1; m_t = 0; m_g = int'(gate_len);
        mc[0] = 0; mc[1] = 0; m_done = 0;
      end
      m_busy = m_act && m_t >= 1;
      m_orst = (m_act && m_t >= 1 && m_t <= R) ? 2'b11 : 2'b00;
      m_prev = osc_in;
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("busy_a", 32'(busy_a), 32'(m_busy));
      chk("busy_b", 32'(busy_b), 32'(m_busy));
      chk("osc_rst_a", 32'(osc_rst_a), 32'(m_orst));
      chk("osc_rst_b", 32'(osc_rst_b), 32'(m_orst));
      chk("done_a", 32'(done_a), 32'(m_done));
      chk("done_b", 32'(done_b), 32'(m_done));
      chk("dout_a", 32'(dout_a), 32'(m_dout_a));
      chk("dout_b", 32'(dout_b), 32'(m_dout_b));
      if (m_done) begin
        chk("ovf_a", 32'(ovf_a), 32'({mres[1] > 65535, mres[0] > 65535}));
        for (int c = 0; c < 2; c++)
          if (mres[c] != 255) chk("ovf_b", 32'(ovf_b[c]), 32'(mres[c] > 255));
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'({busy_a, busy_b}), 32'(0));
    chk({tag, "_osc_rst"}, 32'({osc_rst_a, osc_rst_b}), 32'(0));
    chk({tag, "_done"}, 32'({done_a, done_b}), 32'(0));
    chk({tag, "_ovf"}, 32'({ovf_a, ovf_b}), 32'(0));
    chk({tag, "_dout"}, 32'({dout_a, dout_b}), 32'(0));
  endtask

  // One measurement; returns the edge (relative to acceptance) where done rose.
  task automatic run_meas(input int g, input int inj_at, input int inj_g, input int abort_at,
                          output int done_edge, output int orst_cyc);
    int n;
    done_edge = -1;
    orst_cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; gate_len = 16'(g);
    @(posedge clk); #1;
    start = 1'b0; gate_len = 16'($urandom);
    n = 0;
    while (n < 5000) begin
      @(posedge clk); n++; #1;
      start = 1'b0;
      if (osc_rst_a == 2'b11) orst_cyc++;
      if (done_a) begin
        done_edge = n;
        break;
      end
      if (n == abort_at) begin
        #2; rst = 1'b1; #1;
        reset_checks("async_rst");
        @(negedge clk); rst = 1'b0;
        break;
      end
      if (n == inj_at) begin
        start = 1'b1; gate_len = 16'(inj_g);
      end
    end
  endtask

  task automatic read_sel(input logic [1:0] s, output logic [7:0] da, output logic [7:0] db);
    @(posedge clk); #1;
    sel = s;
    @(posedge clk); #1;
    da = dout_a; db = dout_b;
  endtask

  initial begin
    int de, oc, g, inj, abt;
    logic [7:0] a0, b0, a1, b1;
    rst = 1'b1; start = 1'b0; gate_len = '0; sel = 2'b00; osc_in = 2'b00;
    for (int c = 0; c < 2; c++) begin mode[c] = 0; per[c] = 2; ph[c] = 0; end
    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    @(negedge clk); rst = 1'b0; chk_on = 1;

    // Periods 4 and 10 over a 100-cycle gate.
    mode[0] = 1; per[0] = 4; mode[1] = 1; per[1] = 10;
    run_meas(100, -1, 0, -1, de, oc);
    chk("t2_done_edge", 32'(de), 32'(109));
    chk("t2_osc_rst_cycles", 32'(oc), 32'(8));
    read_sel(2'b00, a0, b0);
    chk_rng("t2_ch0_a", int'(a0), 24, 26);
    chk_rng("t2_ch0_b", int'(b0), 24, 26);
    read_sel(2'b10, a0, b0);
    chk_rng("t2_ch1_a", int'(a0), 9, 11);
    read_sel(2'b01, a0, b0);
    chk("t2_ch0_hi", 32'({a0, b0}), 32'(0));
    read_sel(2'b11, a0, b0);
    chk("t2_ch1_hi", 32'({a0, b0}), 32'(0));
    chk("t2_ovf", 32'({ovf_a, ovf_b}), 32'(0));

    // Restart attempt at gate cycle 5 with a different length is ignored.
    mode[0] = 2; mode[1] = 2;
    run_meas(50, R + 1 + 5, 7, -1, de, oc);
    chk("t4_done_edge", 32'(de), 32'(59));

    // Zero-length gate: reset window only, both results zero.
    mode[0] = 1; per[0] = 4; mode[1] = 1; per[1] = 6;
    run_meas(0, -1, 0, -1, de, oc);
    chk("t6_done_edge", 32'(de), 32'(9));
    chk("t6_osc_rst_cycles", 32'(oc), 32'(8));
    read_sel(2'b00, a0, b0);
    chk("t6_res0", 32'({a0, b0}), 32'(0));
    read_sel(2'b10, a0, b0);
    chk("t6_res1", 32'({a0, b0}), 32'(0));
    chk("t6_ovf", 32'({ovf_a, ovf_b}), 32'(0));

    // Period-2 input over 1000 cycles saturates the 8-bit instance.
    mode[0] = 1; per[0] = 2; mode[1] = 0;
    run_meas(1000, -1, 0, -1, de, oc);
    chk("t3_done_edge", 32'(de), 32'(1009));
    read_sel(2'b00, a0, b0);
    read_sel(2'b01, a1, b1);
    chk("t3_res0_b", 32'(b0), 32'(8'hFF));
    chk("t3_res0_hi_b", 32'(b1), 32'(0));
    chk_rng("t3_res0_a", int'({a1, a0}), 499, 501);
    read_sel(2'b10, a0, b0);
    chk("t3_res1", 32'({a0, b0}), 32'(0));
    chk("t3_ovf_b", 32'(ovf_b), 32'(2'b01));
    chk("t3_ovf_a", 32'(ovf_a), 32'(2'b00));

    // Abort at gate cycle 30, then a fresh 20-cycle measurement.
    sel = 2'b00;
    run_meas(100, R + 1 + 30, 0, R + 1 + 30, de, oc);
    mode[0] = 1; per[0] = 4; mode[1] = 1; per[1] = 8;
    run_meas(20, -1, 0, -1, de, oc);
    chk("t5_done_edge", 32'(de), 32'(29));
    read_sel(2'b00, a0, b0);
    chk_rng("t5_res0", int'(a0), 4, 6);

    // Randomized measurements with stray starts and occasional aborts.
    sel_rand = 1;
    for (int i = 0; i < 25; i++) begin
      for (int c = 0; c < 2; c++) begin
        mode[c] = $urandom_range(0, 2);
        per[c] = $urandom_range(2, 24);
      end
      g = $urandom_range(0, 80);
      inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8 + g) : -1;
      abt = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8 + g) : -1;
      run_meas(g, inj, $urandom_range(0, 80), abt, de, oc);
      if (abt < 0) chk("rand_done_edge", 32'(de), 32'(9 + g));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    sel_rand = 0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
